// File: rtl/avr_bus_pkg.sv
// avr_bus_pkg: shared types and constants for the AVR bus router.
//   state_t  : access FSM states (IDLE, WAIT, DONE)
//   sel_t    : registered read-select code, SEL_MISS marks an unmapped access
//   WAIT_W   : width of the per-region wait-state field and counter
package avr_bus_pkg;
    localparam int WAIT_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef logic [3:0] sel_t;
    localparam sel_t SEL_MISS = 4'hF;
endpackage

// File: rtl/avr_bus_if.sv
// avr_bus_if: CPU-side bus, per-channel memory bus and fault capture signals.
//   master : CPU/memory side (drives address, we, read, data_o, ch_q, fault_clr)
//   slave  : router side (drives data_i, ce, ch_a, ch_d, ch_we, fault_*)
interface avr_bus_if #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8
);
    logic [ADDR_W-1:0]          address;
    logic                       we;
    logic                       read;
    logic [DATA_W-1:0]          data_o;
    logic [DATA_W-1:0]          data_i;
    logic                       ce;
    logic [ADDR_W-1:0]          ch_a;
    logic [DATA_W-1:0]          ch_d;
    logic [CHANNELS-1:0]        ch_we;
    logic [CHANNELS*DATA_W-1:0] ch_q;
    logic                       fault_irq;
    logic [ADDR_W-1:0]          fault_addr;
    logic                       fault_we;
    logic                       fault_clr;

    modport master (
        output address, we, read, data_o, ch_q, fault_clr,
        input  data_i, ce, ch_a, ch_d, ch_we, fault_irq, fault_addr, fault_we
    );
    modport slave (
        input  address, we, read, data_o, ch_q, fault_clr,
        output data_i, ce, ch_a, ch_d, ch_we, fault_irq, fault_addr, fault_we
    );
endinterface

// File: rtl/avr_bus_decode.sv
// avr_bus_decode: combinational address decoder.
//   address : CPU address
//   hit     : address falls inside some region
//   idx     : index of the lowest-numbered matching region
//   offset  : address minus the region base (0 on a miss)
module avr_bus_decode #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter logic [CHANNELS*ADDR_W-1:0]     REGION_BASE = 64'hC000_8000_0000_1000,
    parameter logic [CHANNELS*(ADDR_W+1)-1:0] REGION_SIZE = {17'h00100, 17'h02000, 17'h01000, 17'h00800}
) (
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic [2:0]        idx,
    output logic [ADDR_W-1:0] offset
);
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        // Scan from the top so the lowest-index match is written last and wins.
        // Bounds carry one extra bit so a region ending at 2^ADDR_W cannot wrap.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if ({1'b0, address} >= {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} &&
                {1'b0, address} <  {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} + REGION_SIZE[k*(ADDR_W+1) +: ADDR_W+1]) begin
                hit    = 1'b1;
                idx    = k[2:0];
                offset = address - REGION_BASE[k*ADDR_W +: ADDR_W];
            end
        end
    end
endmodule

// File: rtl/avr_bus_router.sv
// avr_bus_router: routes CPU accesses to memory regions with per-region wait states.
//   clock, reset_n : system clock, synchronous active-low reset
//   bus (slave)    : CPU request/response, per-channel strobes and read data,
//                    unmapped-access capture (fault_*)
// Optional feature: define AVR_BUS_FAULT_EN to enable unmapped-access capture;
// otherwise the fault outputs are tied to 0 and fault_clr is ignored.
module avr_bus_router
    import avr_bus_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter logic [CHANNELS*ADDR_W-1:0]     REGION_BASE = 64'hC000_8000_0000_1000,
    parameter logic [CHANNELS*(ADDR_W+1)-1:0] REGION_SIZE = {17'h00100, 17'h02000, 17'h01000, 17'h00800},
    parameter logic [CHANNELS*WAIT_W-1:0]     REGION_WAIT = 16'h2000,
    parameter logic [DATA_W-1:0]              MISS_DATA   = '0
) (
    input logic clock,
    input logic reset_n,
    avr_bus_if.slave bus
);
    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    sel_t              sel_q, sel_d;
    logic              hit, req, ce_raw, we_raw;
    logic [2:0]        idx;
    logic [WAIT_W-1:0] wait_w;
    sel_t              acc_sel;

    avr_bus_decode #(
        .CHANNELS(CHANNELS), .ADDR_W(ADDR_W),
        .REGION_BASE(REGION_BASE), .REGION_SIZE(REGION_SIZE)
    ) u_decode (
        .address(bus.address), .hit(hit), .idx(idx), .offset(bus.ch_a)
    );

    assign req     = bus.we || bus.read;
    assign wait_w  = hit ? REGION_WAIT[idx*WAIT_W +: WAIT_W] : '0;
    assign acc_sel = hit ? sel_t'(idx) : SEL_MISS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ce_raw  = 1'b1;
        we_raw  = 1'b0;
        unique case (state_q)
            IDLE: if (req) begin
                if (wait_w != '0) begin
                    ce_raw  = 1'b0;
                    cnt_d   = wait_w - WAIT_W'(1);
                    // The IDLE cycle is itself the first stall, so W=1 needs no WAIT cycles.
                    state_d = (wait_w == WAIT_W'(1)) ? DONE : WAIT;
                end else begin
                    we_raw = bus.we;
                    sel_d  = acc_sel;
                end
            end
            WAIT: begin
                ce_raw  = 1'b0;
                cnt_d   = cnt_q - WAIT_W'(1);
                state_d = (cnt_q == WAIT_W'(1)) ? DONE : WAIT;
            end
            DONE: begin
                we_raw  = bus.we;
                sel_d   = acc_sel;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_MISS;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.ce     = !reset_n || ce_raw;
    assign bus.ch_we  = (reset_n && we_raw && hit) ? (CHANNELS'(1) << idx) : '0;
    assign bus.ch_d   = bus.data_o;
    assign bus.data_i = (!reset_n || sel_q == SEL_MISS) ? MISS_DATA : bus.ch_q[sel_q*DATA_W +: DATA_W];

`ifdef AVR_BUS_FAULT_EN
    logic              fault_irq_q, fault_irq_d, fault_we_q, fault_we_d, miss_req, cap;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    assign miss_req = state_q == IDLE && req && !hit;

    always_comb begin
        // A new fault wins over a same-cycle clear so it is never lost.
        cap          = miss_req && (!fault_irq_q || bus.fault_clr);
        fault_irq_d  = miss_req || (fault_irq_q && !bus.fault_clr);
        fault_addr_d = cap ? bus.address : fault_addr_q;
        fault_we_d   = cap ? bus.we : fault_we_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fault_irq_q  <= 1'b0;
            fault_addr_q <= '0;
            fault_we_q   <= 1'b0;
        end else begin
            fault_irq_q  <= fault_irq_d;
            fault_addr_q <= fault_addr_d;
            fault_we_q   <= fault_we_d;
        end
    end

    assign bus.fault_irq  = fault_irq_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.fault_we   = fault_we_q;
`else
    assign bus.fault_irq  = 1'b0;
    assign bus.fault_addr = '0;
    assign bus.fault_we   = 1'b0;
`endif
endmodule
